led_tape_ctrl: RTL and testbench

Parametrised WS2812B-class tape driver: successor to the fixed 24-bit LED tape controller. Fetches per-LED colour words over a req/num pull interface and serialises them MSB-first as pulse-width-coded bits on one data line, then holds the line low for a reset gap. Adds configurable bit width for RGB or RGBW parts and cycle-count bit timing. Also adds single-shot and continuous frame modes and optional per-frame brightness scaling. Sits between the pattern generator and the tape pin; the WS2812B emulator chain is its bench load.

---
 rtl/led_tape_ctrl.sv | 197 +++++++++++++++++++
 tb/tb_led_tape_ctrl.sv | 317 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/led_tape_ctrl.sv
// WS2812B-class tape driver: pulls colour words over req/num and serialises them as pulse-width bits.
// Optional per-frame brightness scaling is compiled in with `define LED_TAPE_BRIGHT_EN.
module led_tape_ctrl #(
    parameter int NUM_LEDS       = 7,
    parameter int NUM_RESET_LEDS = 10,
    parameter int COLOR_BITS     = 24,
    parameter int TBIT           = 3,
    parameter int T0H            = 1,
    parameter int T1H            = 2
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  start,
    input  logic                  continuous,
    input  logic [7:0]            brightness,
    input  logic [COLOR_BITS-1:0] RGB,
    output logic                  req,
    output logic [15:0]           num,
    output logic                  sync,
    output logic                  busy,
    output logic                  data
);

    localparam int GAP_LEN = NUM_RESET_LEDS * COLOR_BITS * TBIT;
    localparam int SW      = $clog2(TBIT);
    localparam int BW      = $clog2(COLOR_BITS);
    localparam int GW      = $clog2(GAP_LEN);

    typedef enum logic [1:0] {IDLE, PRE, SEND, GAP} state_t;

    state_t                state, state_n;
    logic                  pre_cnt, pre_cnt_n;
    logic [SW-1:0]         slot_cnt, slot_n;
    logic [BW-1:0]         bit_cnt, bit_n;
    logic [15:0]           led_cnt, led_n;
    logic [GW-1:0]         gap_cnt, gap_n;
    logic [COLOR_BITS-1:0] shifter, shift_n;
    logic [COLOR_BITS-1:0] hold, hold_n;
    logic                  pending, pending_n;
    logic                  req_n, sync_n, busy_n, data_n;
    logic [15:0]           num_n;
    logic [COLOR_BITS-1:0] rgb_in;

`ifdef LED_TAPE_BRIGHT_EN
    logic [7:0]  bright_q;
    logic [15:0] prod;

    always_ff @(posedge clk) begin
        if (reset)
            bright_q <= '0;
        else if (state == PRE && !pre_cnt)
            bright_q <= brightness;
    end

    // Each byte becomes (f * (b + 1)) >> 8, so b = 255 leaves the word untouched.
    always_comb begin
        rgb_in = RGB;
        prod   = '0;
        for (int i = 0; i < COLOR_BITS / 8; i++) begin
            prod = 16'(RGB[i*8 +: 8]) * (16'(bright_q) + 16'd1);
            rgb_in[i*8 +: 8] = prod[15:8];
        end
    end
`else
    logic unused_brightness;
    assign unused_brightness = ^brightness;
    assign rgb_in = RGB;
`endif

    always_ff @(posedge clk) begin
        if (reset) begin
            state    <= IDLE;
            pre_cnt  <= 1'b0;
            slot_cnt <= '0;
            bit_cnt  <= '0;
            led_cnt  <= '0;
            gap_cnt  <= '0;
            shifter  <= '0;
            hold     <= '0;
            pending  <= 1'b0;
            req      <= 1'b0;
            num      <= '0;
            sync     <= 1'b0;
            busy     <= 1'b0;
            data     <= 1'b0;
        end else begin
            state    <= state_n;
            pre_cnt  <= pre_cnt_n;
            slot_cnt <= slot_n;
            bit_cnt  <= bit_n;
            led_cnt  <= led_n;
            gap_cnt  <= gap_n;
            shifter  <= shift_n;
            hold     <= hold_n;
            pending  <= pending_n;
            req      <= req_n;
            num      <= num_n;
            sync     <= sync_n;
            busy     <= busy_n;
            data     <= data_n;
        end
    end

    // All outputs are computed for the next cycle so they leave the block registered.
    always_comb begin
        state_n   = state;
        pre_cnt_n = pre_cnt;
        slot_n    = slot_cnt;
        bit_n     = bit_cnt;
        led_n     = led_cnt;
        gap_n     = gap_cnt;
        shift_n   = shifter;
        hold_n    = hold;
        pending_n = pending | (start & busy);
        req_n     = 1'b0;
        num_n     = num;
        busy_n    = busy;

        case (state)
            IDLE: begin
                if (start | continuous | pending) begin
                    state_n   = PRE;
                    pre_cnt_n = 1'b0;
                    req_n     = 1'b1;
                    num_n     = '0;
                    busy_n    = 1'b1;
                    pending_n = 1'b0;
                end
            end
            PRE: begin
                if (!pre_cnt) begin
                    pre_cnt_n = 1'b1;
                end else begin
                    state_n = SEND;
                    shift_n = rgb_in;
                    slot_n  = '0;
                    bit_n   = '0;
                    led_n   = '0;
                    if (NUM_LEDS > 1) begin
                        req_n = 1'b1;
                        num_n = 16'd1;
                    end
                end
            end
            SEND: begin
                // The prefetched word arrives one cycle after the req pulse.
                if (bit_cnt == '0 && slot_cnt == SW'(1))
                    hold_n = rgb_in;
                if (slot_cnt == SW'(TBIT - 1)) begin
                    slot_n = '0;
                    if (bit_cnt == BW'(COLOR_BITS - 1)) begin
                        bit_n = '0;
                        if (led_cnt == 16'(NUM_LEDS - 1)) begin
                            state_n = GAP;
                            gap_n   = '0;
                            num_n   = 16'(NUM_LEDS);
                        end else begin
                            led_n   = led_cnt + 16'd1;
                            shift_n = hold;
                            if (led_cnt + 16'd2 < 16'(NUM_LEDS)) begin
                                req_n = 1'b1;
                                num_n = led_cnt + 16'd2;
                            end
                        end
                    end else begin
                        bit_n   = bit_cnt + BW'(1);
                        shift_n = {shifter[COLOR_BITS-2:0], 1'b0};
                    end
                end else begin
                    slot_n = slot_cnt + SW'(1);
                end
            end
            GAP: begin
                if (gap_cnt == GW'(GAP_LEN - 1)) begin
                    pending_n = 1'b0;
                    if (continuous | pending | start) begin
                        state_n   = PRE;
                        pre_cnt_n = 1'b0;
                        req_n     = 1'b1;
                        num_n     = '0;
                    end else begin
                        state_n = IDLE;
                        busy_n  = 1'b0;
                    end
                end else begin
                    gap_n = gap_cnt + GW'(1);
                end
            end
            default: state_n = IDLE;
        endcase

        sync_n = (state_n == GAP);
        data_n = (state_n == SEND) &&
                 (slot_n < (shift_n[COLOR_BITS-1] ? SW'(T1H) : SW'(T0H)));
    end

endmodule

// File: tb/tb_led_tape_ctrl.sv
// Bench for led_tape_ctrl: a default-parameter instance plus a 32-bit single-LED instance,
// each line decoded back into pulse widths and colour words.
module tb_led_tape_ctrl;

`ifdef LED_TAPE_BRIGHT_EN
    localparam bit BRIGHT = 1'b1;
`else
    localparam bit BRIGHT = 1'b0;
`endif

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        reset;
    logic        start0, cont0, req0, sync0, busy0, data0;
    logic [7:0]  bright0;
    logic [23:0] rgb0;
    logic [15:0] num0;
    logic        start1, cont1, req1, sync1, busy1, data1;
    logic [7:0]  bright1;
    logic [31:0] rgb1;
    logic [15:0] num1;

    logic        use_colour;
    logic [23:0] vec_rgb;
    int          sync_total = 0;
    int          colour_base;

    led_tape_ctrl dut0 (
        .clk(clk), .reset(reset), .start(start0), .continuous(cont0),
        .brightness(bright0), .RGB(rgb0), .req(req0), .num(num0),
        .sync(sync0), .busy(busy0), .data(data0)
    );

    led_tape_ctrl #(
        .NUM_LEDS(1), .NUM_RESET_LEDS(10), .COLOR_BITS(32),
        .TBIT(4), .T0H(1), .T1H(3)
    ) dut1 (
        .clk(clk), .reset(reset), .start(start1), .continuous(cont1),
        .brightness(bright1), .RGB(rgb1), .req(req1), .num(num1),
        .sync(sync1), .busy(busy1), .data(data1)
    );

    // Colour source answering on num; in colour mode xx follows the sync rising-edge count.
    always_comb begin
        if (use_colour)
            rgb0 = {16'hA5B6, 8'(sync_total - colour_base)};
        else if (num0 == 16'd0)
            rgb0 = vec_rgb;
        else
            rgb0 = {16'hA5B6, num0[7:0]};
    end

    // Line receivers: high width per slot, width T1H decodes as a '1'.
    int          hi0 = 0, nb0 = 0, hi1 = 0;
    logic [23:0] shreg0 = '0;
    logic [23:0] words0[$];
    int          w0[$];
    int          w1[$];
    logic        sync0_d = 1'b0;

    always @(negedge clk) begin
        if (sync0 && !sync0_d)
            sync_total++;
        sync0_d = sync0;
        if (reset) begin
            hi0 = 0;
            nb0 = 0;
        end else if (data0) begin
            hi0++;
        end else if (hi0 != 0) begin
            w0.push_back(hi0);
            shreg0 = {shreg0[22:0], hi0 == 2};
            nb0++;
            if (nb0 == 24) begin
                words0.push_back(shreg0);
                nb0 = 0;
            end
            hi0 = 0;
        end
    end

    always @(negedge clk) begin
        if (reset)
            hi1 = 0;
        else if (data1)
            hi1++;
        else if (hi1 != 0) begin
            w1.push_back(hi1);
            hi1 = 0;
        end
    end

    typedef struct {
        logic [23:0] rgb;
        logic [7:0]  bright;
        logic [23:0] expect_word;
    } vec_t;

    vec_t vecs[5];
    int   total = 0, bad = 0;
    int   busy_len, sync_len, sync_rises, first_num, gap_num;
    int   req_at[$];

    task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
        total++;
        if (actual !== expected) begin
            bad++;
            $display("[TB] FAIL %s: actual=%0h required=%0h", name, actual, expected);
        end
    endtask

    function automatic logic [23:0] expWord(input logic [23:0] w, input logic [7:0] b);
        logic [23:0] r;
        logic [15:0] p;
        r = w;
        if (BRIGHT) begin
            for (int k = 0; k < 3; k++) begin
                p = 16'(w[k*8 +: 8]) * (16'(b) + 16'd1);
                r[k*8 +: 8] = p[15:8];
            end
        end
        return r;
    endfunction

    task automatic pulseStart0();
        @(posedge clk); #1 start0 = 1'b1;
        @(posedge clk); #1 start0 = 1'b0;
    endtask

    // Follows dut0 until busy drops; positions are counted from the first busy cycle.
    task automatic measureFrame0(input int limit);
        int   t;
        logic seen, done, prev_sync;
        busy_len = 0; sync_len = 0; sync_rises = 0; first_num = -1; gap_num = -1;
        req_at.delete();
        seen = 1'b0; done = 1'b0; prev_sync = 1'b0; t = 0;
        while (!done && t < limit) begin
            @(negedge clk);
            t++;
            if (busy0 && !seen) begin
                seen = 1'b1;
                first_num = int'(num0);
            end
            if (seen && !busy0) begin
                done = 1'b1;
            end else if (busy0) begin
                if (req0) req_at.push_back(busy_len);
                if (sync0) begin
                    sync_len++;
                    gap_num = int'(num0);
                end
                if (sync0 && !prev_sync) sync_rises++;
                busy_len++;
            end
            prev_sync = sync0;
        end
        if (!done) checkOutput("frame_timeout", 32'd0, 32'd1);
    endtask

    task automatic applyStimulus(input logic [23:0] rgb, input logic [7:0] b);
        vec_rgb = rgb;
        bright0 = b;
        words0.delete();
        w0.delete();
        pulseStart0();
        measureFrame0(3000);
    endtask

    initial begin
        int t, mism, hi_run, first_run, bl1, sl1;
        logic prev, seen1, done1;
        int rises[$];

        vecs[0] = '{24'hA5B631, 8'hFF, 24'hA5B631};
        vecs[1] = '{24'hFF8040, 8'd127, BRIGHT ? 24'h7F4020 : 24'hFF8040};
        vecs[2] = '{24'hA5B631, 8'd128, BRIGHT ? 24'h535B18 : 24'hA5B631};
        vecs[3] = '{24'hFFFFFF, 8'd0,   BRIGHT ? 24'h000000 : 24'hFFFFFF};
        vecs[4] = '{24'h123456, 8'hFF, 24'h123456};

        reset = 1'b1; start0 = 1'b0; cont0 = 1'b0; bright0 = 8'hFF;
        vec_rgb = '0; use_colour = 1'b0; colour_base = 0;
        start1 = 1'b0; cont1 = 1'b0; bright1 = 8'hFF; rgb1 = 32'h80000001;

        repeat (3) @(posedge clk);
        @(negedge clk);
        checkOutput("reset_outs0", {28'd0, data0, req0, sync0, busy0}, 32'd0);
        checkOutput("reset_num0", {16'd0, num0}, 32'd0);
        checkOutput("reset_outs1", {28'd0, data1, req1, sync1, busy1}, 32'd0);
        @(posedge clk); #1 reset = 1'b0;

        for (int i = 0; i < 5; i++) begin
            applyStimulus(vecs[i].rgb, vecs[i].bright);
            checkOutput("busy_len", busy_len, 32'd1226);
            checkOutput("first_num", first_num, 32'd0);
            checkOutput("word_count", words0.size(), 32'd7);
            checkOutput("led0_word", {8'd0, words0[0]}, {8'd0, vecs[i].expect_word});
            mism = 0;
            for (int k = 1; k < 7; k++)
                if (words0[k] !== expWord({16'hA5B6, 8'(k)}, vecs[i].bright)) mism++;
            checkOutput("led1to6_words", mism, 32'd0);
            mism = 0;
            for (int k = 0; k < 24; k++)
                if (w0[k] != (vecs[i].expect_word[23-k] ? 2 : 1)) mism++;
            checkOutput("led0_widths", mism, 32'd0);
            checkOutput("req_count", req_at.size(), 32'd7);
            checkOutput("req_pos1", req_at[1], 32'd2);
            checkOutput("req_pos3", req_at[3], 32'd146);
            checkOutput("req_pos6", req_at[6], 32'd362);
            checkOutput("gap_num", gap_num, 32'd7);
            checkOutput("sync_len", sync_len, 32'd720);
        end

        // Continuous frames with a colour counter stepped on each sync rising edge.
        bright0 = 8'hFF;
        words0.delete();
        colour_base = sync_total;
        use_colour = 1'b1;
        @(posedge clk); #1 cont0 = 1'b1;
        t = 0; rises.delete(); prev = 1'b0; hi_run = 0; first_run = 0;
        while (rises.size() < 3 && t < 6000) begin
            @(negedge clk);
            t++;
            if (sync0) hi_run++;
            else begin
                if (hi_run != 0 && first_run == 0) first_run = hi_run;
                hi_run = 0;
            end
            if (sync0 && !prev) rises.push_back(t);
            prev = sync0;
        end
        checkOutput("cont_rises", rises.size(), 32'd3);
        checkOutput("cont_period1", rises[1] - rises[0], 32'd1226);
        checkOutput("cont_period2", rises[2] - rises[1], 32'd1226);
        checkOutput("cont_sync_len", first_run, 32'd720);
        repeat (800) @(negedge clk);
        @(posedge clk); #1 cont0 = 1'b0;
        measureFrame0(3000);
        checkOutput("cont_last_gaps", sync_rises, 32'd1);
        checkOutput("cont_words", words0.size(), 32'd28);
        for (int f = 0; f < 4; f++) begin
            mism = 0;
            for (int k = 0; k < 7; k++)
                if (words0[f*7 + k] !== {16'hA5B6, 8'(f)}) mism++;
            checkOutput("cont_frame_words", mism, 32'd0);
        end
        use_colour = 1'b0;
        repeat (5) @(negedge clk);
        checkOutput("cont_stop_idle", {31'd0, busy0}, 32'd0);

        // Reset while LED 3 is on the line.
        vec_rgb = 24'hA5B631;
        pulseStart0();
        t = 0;
        while (num0 != 16'd4 && t < 1000) begin
            @(negedge clk);
            t++;
        end
        checkOutput("reach_led3", {16'd0, num0}, 32'd4);
        @(posedge clk); #1 reset = 1'b1;
        @(posedge clk);
        @(negedge clk);
        checkOutput("midreset_outs", {28'd0, data0, req0, sync0, busy0}, 32'd0);
        checkOutput("midreset_num", {16'd0, num0}, 32'd0);
        @(posedge clk); #1 reset = 1'b0;
        applyStimulus(24'hA5B631, 8'hFF);
        checkOutput("after_reset_len", busy_len, 32'd1226);
        checkOutput("after_reset_num", first_num, 32'd0);
        checkOutput("after_reset_words", words0.size(), 32'd7);
        checkOutput("after_reset_word0", {8'd0, words0[0]}, 32'h00A5B631);

        // Two starts during a busy frame give exactly one extra frame.
        vec_rgb = 24'h123456;
        words0.delete();
        pulseStart0();
        repeat (100) @(posedge clk);
        pulseStart0();
        repeat (100) @(posedge clk);
        pulseStart0();
        measureFrame0(4000);
        checkOutput("dbl_frames", sync_rises, 32'd2);
        checkOutput("dbl_words", words0.size(), 32'd14);
        checkOutput("dbl_sync_len", sync_len, 32'd1440);
        repeat (20) @(negedge clk);
        checkOutput("dbl_idle", {31'd0, busy0}, 32'd0);

        // 32-bit single-LED instance with 4-cycle slots.
        @(posedge clk); #1 start1 = 1'b1;
        @(posedge clk); #1 start1 = 1'b0;
        t = 0; bl1 = 0; sl1 = 0; seen1 = 1'b0; done1 = 1'b0;
        while (!done1 && t < 4000) begin
            @(negedge clk);
            t++;
            if (busy1) begin
                seen1 = 1'b1;
                bl1++;
                if (sync1) sl1++;
            end else if (seen1) begin
                done1 = 1'b1;
            end
        end
        checkOutput("w32_done", {31'd0, done1}, 32'd1);
        checkOutput("w32_slots", w1.size(), 32'd32);
        checkOutput("w32_first", w1[0], 32'd3);
        mism = 0;
        for (int k = 1; k < 31; k++)
            if (w1[k] == 1) mism++;
        checkOutput("w32_ones", mism, 32'd30);
        checkOutput("w32_last", w1[31], 32'd3);
        checkOutput("w32_gap", sl1, 32'd1280);
        checkOutput("w32_busy", bl1, 32'd1410);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
